operand_fetch_unit: RTL and testbench

- Multi-cycle source/destination operand fetcher for the PDP-11 core, used by the decode/execute FSM.
- Implements all eight PDP-11 addressing modes (0-7) on any register, in byte or word form.
- Handles register side effects (autoincrement/autodecrement, PC advance past index words) and memory accesses through a req/ready handshake.
- Returns the operand value and its effective address, and flags odd word addresses.

---
 rtl/operand_fetch_unit_pkg.sv | 23 ++
 rtl/operand_fetch_unit_ea_calc.sv | 57 +++++
 rtl/operand_fetch_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_operand_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// Shared types and defaults for the PDP-11 operand fetch unit.
package operand_fetch_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned NUM_REGS_DEF   = 8;
  localparam int unsigned SP_INDEX_DEF   = 6;
  localparam int unsigned PC_INDEX_DEF   = 7;

  typedef enum logic [2:0] {
    IDLE, CALC, FETCH_X, FETCH_PTR, FETCH_OPND, DONE
  } fetch_state_t;

  typedef enum logic [2:0] {
    REG, REG_DEF, AUTOINC, AUTOINC_DEF, AUTODEC, AUTODEC_DEF, INDEX, INDEX_DEF
  } addr_mode_t;

  // Modes that go through a pointer word before reaching the operand.
  function automatic logic is_ptr_mode(addr_mode_t m);
    return (m == AUTOINC_DEF) || (m == AUTODEC_DEF) || (m == INDEX_DEF);
  endfunction

endpackage

// File: rtl/operand_fetch_unit_ea_calc.sv
// Combinational step size, register write-back, effective/pointer address and odd-address checks.
module ea_calc
  import operand_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned RSW        = 3,
  parameter int unsigned SP_INDEX   = SP_INDEX_DEF,
  parameter int unsigned PC_INDEX   = PC_INDEX_DEF
) (
  input  addr_mode_t            i_mode,
  input  logic [RSW-1:0]        i_reg_sel,
  input  logic                  i_byte_op,
  input  logic [DATA_WIDTH-1:0] i_r,
  input  logic [DATA_WIDTH-1:0] i_x,
  output logic                  o_wb_en,
  output logic [DATA_WIDTH-1:0] o_wb_val,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_addr_odd,
  output logic [ADDR_WIDTH-1:0] o_idx,
  output logic                  o_idx_odd
);

  logic                  w_ptr;
  logic                  w_sp_pc;
  logic                  w_word;
  logic [DATA_WIDTH-1:0] w_step;
  logic [DATA_WIDTH-1:0] w_base;

  always_comb begin
    w_ptr    = is_ptr_mode(i_mode);
    w_sp_pc  = (i_reg_sel == RSW'(SP_INDEX)) || (i_reg_sel == RSW'(PC_INDEX));
    w_word   = !i_byte_op || w_ptr;
    w_step   = (i_byte_op && !w_sp_pc && !w_ptr) ? DATA_WIDTH'(1) : DATA_WIDTH'(2);
    o_wb_en  = 1'b0;
    o_wb_val = i_r;
    o_addr   = ADDR_WIDTH'(i_r);
    case (i_mode)
      AUTOINC, AUTOINC_DEF: begin
        o_wb_en  = 1'b1;
        o_wb_val = i_r + w_step;
      end
      AUTODEC, AUTODEC_DEF: begin
        o_wb_en  = 1'b1;
        o_wb_val = i_r - w_step;
        o_addr   = ADDR_WIDTH'(i_r - w_step);
      end
      default: ;
    endcase
    o_addr_odd = w_word && o_addr[0];
    // PC-relative indexing is taken from the PC already advanced past the index word.
    w_base    = (i_reg_sel == RSW'(PC_INDEX)) ? i_r + DATA_WIDTH'(2) : i_r;
    o_idx     = ADDR_WIDTH'(w_base + i_x);
    o_idx_odd = w_word && o_idx[0];
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Multi-cycle PDP-11 operand fetcher: walks the addressing mode, applies register side effects, reads memory.
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned SP_INDEX   = SP_INDEX_DEF,
  parameter int unsigned PC_INDEX   = PC_INDEX_DEF,
  localparam int unsigned RSW       = $clog2(NUM_REGS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [2:0]            i_mode,
  input  logic [RSW-1:0]        i_reg_sel,
  input  logic                  i_byte_op,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_operand,
  output logic [ADDR_WIDTH-1:0] o_eff_addr,
  output logic                  o_is_reg,
  output logic                  o_addr_err,
  output logic [RSW-1:0]        o_rf_rd_sel,
  input  logic [DATA_WIDTH-1:0] i_rf_rd_data,
  output logic                  o_rf_wr_en,
  output logic [RSW-1:0]        o_rf_wr_sel,
  output logic [DATA_WIDTH-1:0] o_rf_wr_data,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  fetch_state_t          r_state, w_state_nx;
  addr_mode_t            r_mode, w_mode_nx;
  logic [RSW-1:0]        r_reg, w_reg_nx;
  logic                  r_byte, w_byte_nx;
  logic [DATA_WIDTH-1:0] r_r, w_r_nx;
  logic [ADDR_WIDTH-1:0] r_ea, w_ea_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;
  logic [DATA_WIDTH-1:0] r_operand, w_operand_nx;
  logic [ADDR_WIDTH-1:0] r_eff_addr, w_eff_addr_nx;
  logic                  r_is_reg, w_is_reg_nx;
  logic                  r_addr_err, w_addr_err_nx;
  logic                  r_wr_en, w_wr_en_nx;
  logic [RSW-1:0]        r_wr_sel, w_wr_sel_nx;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nx;
  logic                  r_mem_req, w_mem_req_nx;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nx;
  logic [RSW-1:0]        w_rd_sel;
  logic                  w_hit;

  logic                  w_wb_en, w_addr_odd, w_idx_odd;
  logic [DATA_WIDTH-1:0] w_wb_val;
  logic [ADDR_WIDTH-1:0] w_addr, w_idx, w_ptr_ea;

  ea_calc #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RSW(RSW),
    .SP_INDEX(SP_INDEX), .PC_INDEX(PC_INDEX)
  ) u_ea_calc (
    .i_mode(r_mode), .i_reg_sel(r_reg), .i_byte_op(r_byte), .i_r(r_r), .i_x(i_mem_rdata),
    .o_wb_en(w_wb_en), .o_wb_val(w_wb_val), .o_addr(w_addr), .o_addr_odd(w_addr_odd),
    .o_idx(w_idx), .o_idx_odd(w_idx_odd)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_mode     <= REG;
      r_reg      <= '0;
      r_byte     <= 1'b0;
      r_r        <= '0;
      r_ea       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_operand  <= '0;
      r_eff_addr <= '0;
      r_is_reg   <= 1'b0;
      r_addr_err <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_mode     <= w_mode_nx;
      r_reg      <= w_reg_nx;
      r_byte     <= w_byte_nx;
      r_r        <= w_r_nx;
      r_ea       <= w_ea_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_operand  <= w_operand_nx;
      r_eff_addr <= w_eff_addr_nx;
      r_is_reg   <= w_is_reg_nx;
      r_addr_err <= w_addr_err_nx;
      r_wr_en    <= w_wr_en_nx;
      r_wr_sel   <= w_wr_sel_nx;
      r_wr_data  <= w_wr_data_nx;
      r_mem_req  <= w_mem_req_nx;
      r_mem_addr <= w_mem_addr_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_mode_nx     = r_mode;
    w_reg_nx      = r_reg;
    w_byte_nx     = r_byte;
    w_r_nx        = r_r;
    w_ea_nx       = r_ea;
    w_operand_nx  = r_operand;
    w_eff_addr_nx = r_eff_addr;
    w_is_reg_nx   = r_is_reg;
    w_addr_err_nx = r_addr_err;
    w_wr_en_nx    = 1'b0;
    w_wr_sel_nx   = '0;
    w_wr_data_nx  = '0;
    w_mem_req_nx  = 1'b0;
    w_mem_addr_nx = '0;
    w_rd_sel      = i_reg_sel;
    w_hit         = i_mem_ready && r_mem_req;
    w_ptr_ea      = ADDR_WIDTH'(i_mem_rdata);

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_mode_nx     = addr_mode_t'(i_mode);
          w_reg_nx      = i_reg_sel;
          w_byte_nx     = i_byte_op;
          w_r_nx        = i_rf_rd_data;
          w_operand_nx  = '0;
          w_eff_addr_nx = '0;
          w_is_reg_nx   = 1'b0;
          w_addr_err_nx = 1'b0;
          w_state_nx    = CALC;
        end
      end
      CALC: begin
        w_rd_sel = RSW'(PC_INDEX);
        case (r_mode)
          REG: begin
            w_operand_nx = r_r;
            w_is_reg_nx  = 1'b1;
            w_state_nx   = DONE;
          end
          INDEX, INDEX_DEF: begin
            if (i_rf_rd_data[0]) begin
              w_addr_err_nx = 1'b1;
              w_state_nx    = DONE;
            end else begin
              w_mem_req_nx  = 1'b1;
              w_mem_addr_nx = ADDR_WIDTH'(i_rf_rd_data);
              w_state_nx    = FETCH_X;
            end
          end
          default: begin
            w_wr_en_nx   = w_wb_en;
            w_wr_sel_nx  = r_reg;
            w_wr_data_nx = w_wb_val;
            w_ea_nx      = w_addr;
            if (w_addr_odd) begin
              w_addr_err_nx = 1'b1;
              w_state_nx    = DONE;
            end else begin
              w_mem_req_nx  = 1'b1;
              w_mem_addr_nx = {w_addr[ADDR_WIDTH-1:1], 1'b0};
              w_state_nx    = is_ptr_mode(r_mode) ? FETCH_PTR : FETCH_OPND;
            end
          end
        endcase
      end
      FETCH_X: begin
        w_rd_sel      = RSW'(PC_INDEX);
        w_mem_req_nx  = r_mem_req;
        w_mem_addr_nx = r_mem_addr;
        if (w_hit) begin
          // mem_addr still holds the PC the index word came from.
          w_wr_en_nx    = 1'b1;
          w_wr_sel_nx   = RSW'(PC_INDEX);
          w_wr_data_nx  = DATA_WIDTH'(r_mem_addr + ADDR_WIDTH'(2));
          w_ea_nx       = w_idx;
          w_mem_req_nx  = 1'b0;
          w_mem_addr_nx = '0;
          if (w_idx_odd) begin
            w_addr_err_nx = 1'b1;
            w_state_nx    = DONE;
          end else begin
            w_mem_req_nx  = 1'b1;
            w_mem_addr_nx = {w_idx[ADDR_WIDTH-1:1], 1'b0};
            w_state_nx    = (r_mode == INDEX_DEF) ? FETCH_PTR : FETCH_OPND;
          end
        end
      end
      FETCH_PTR: begin
        w_mem_req_nx  = r_mem_req;
        w_mem_addr_nx = r_mem_addr;
        if (w_hit) begin
          w_ea_nx       = w_ptr_ea;
          w_mem_req_nx  = 1'b0;
          w_mem_addr_nx = '0;
          if (!r_byte && w_ptr_ea[0]) begin
            w_addr_err_nx = 1'b1;
            w_state_nx    = DONE;
          end else begin
            w_mem_req_nx  = 1'b1;
            w_mem_addr_nx = {w_ptr_ea[ADDR_WIDTH-1:1], 1'b0};
            w_state_nx    = FETCH_OPND;
          end
        end
      end
      FETCH_OPND: begin
        w_mem_req_nx  = r_mem_req;
        w_mem_addr_nx = r_mem_addr;
        if (w_hit) begin
          w_mem_req_nx  = 1'b0;
          w_mem_addr_nx = '0;
          w_eff_addr_nx = r_ea;
          if (!r_byte)
            w_operand_nx = i_mem_rdata;
          else if (r_ea[0])
            w_operand_nx = DATA_WIDTH'(i_mem_rdata[15:8]);
          else
            w_operand_nx = DATA_WIDTH'(i_mem_rdata[7:0]);
          w_state_nx = DONE;
        end
      end
      DONE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase

    w_busy_nx = (w_state_nx != IDLE);
    w_done_nx = (w_state_nx == DONE);
  end

  // The read select is the only combinational output; forced to 0 while in reset.
  assign o_rf_rd_sel  = i_reset ? '0 : w_rd_sel;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_operand    = r_operand;
  assign o_eff_addr   = r_eff_addr;
  assign o_is_reg     = r_is_reg;
  assign o_addr_err   = r_addr_err;
  assign o_rf_wr_en   = r_wr_en;
  assign o_rf_wr_sel  = r_wr_sel;
  assign o_rf_wr_data = r_wr_data;
  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed self-checking bench for operand_fetch_unit with a register-file and wait-state memory model.
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [2:0]  reg_sel = 3'd0;
  logic        byte_op = 1'b0;
  logic        busy, done, is_reg, addr_err;
  logic [15:0] operand, eff_addr;
  logic [2:0]  rf_rd_sel, rf_wr_sel;
  logic [15:0] rf_rd_data, rf_wr_data;
  logic        rf_wr_en, mem_req, mem_ready;
  logic [15:0] mem_addr, mem_rdata;

  logic [15:0] regs [0:7];
  logic [15:0] mem  [0:32767];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_sel = 3'd0;
  logic [15:0] poke_val = 16'd0;
  int          waits = 0;
  int          wait_cnt = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          req_count = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  operand_fetch_unit dut (
    .i_clock(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_reg_sel(reg_sel),
    .i_byte_op(byte_op), .o_busy(busy), .o_done(done), .o_operand(operand),
    .o_eff_addr(eff_addr), .o_is_reg(is_reg), .o_addr_err(addr_err),
    .o_rf_rd_sel(rf_rd_sel), .i_rf_rd_data(rf_rd_data), .o_rf_wr_en(rf_wr_en),
    .o_rf_wr_sel(rf_wr_sel), .o_rf_wr_data(rf_wr_data), .o_mem_req(mem_req),
    .o_mem_addr(mem_addr), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign rf_rd_data = regs[rf_rd_sel];
  assign mem_rdata  = mem[mem_addr[15:1]];
  assign mem_ready  = (waits == 0) || (mem_req && (wait_cnt == waits));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) regs[poke_sel] <= poke_val;
    if (rf_wr_en) begin
      regs[rf_wr_sel] <= rf_wr_data;
      wr_count <= wr_count + 1;
    end
    if (mem_req) req_count <= req_count + 1;
    if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [2:0] sel, input logic [15:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = sel; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one start and returns the cycle distance to the done pulse (-1 on timeout).
  task automatic do_fetch(input logic [2:0] m, input logic [2:0] r, input logic b, output int lat);
    int t0;
    @(negedge clk);
    start = 1'b1; mode = m; reg_sel = r; byte_op = b; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wr0, rq0;
    mem[16'h1000 >> 1] = 16'hAB12;
    mem[16'h0200 >> 1] = 16'h0300;
    mem[16'h0300 >> 1] = 16'hBEEF;
    mem[16'h0010 >> 1] = 16'h0020;
    mem[16'h0032 >> 1] = 16'h0040;
    mem[16'h0040 >> 1] = 16'h5555;
    reg_sel = 3'd5;
    poke(3'd2, 16'h1234);
    poke(3'd3, 16'h1001);
    poke(3'd6, 16'h1000);
    poke(3'd1, 16'h0200);
    poke(3'd4, 16'h0103);
    poke(3'd7, 16'h0010);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_rd_sel", 32'(rf_rd_sel), 32'd0);
    chk("rst_operand", 32'(operand), 32'd0);
    reset = 1'b0;

    // Mode 0 on R2
    wr0 = wr_count; rq0 = req_count;
    do_fetch(3'd0, 3'd2, 1'b0, lat);
    chk("m0_latency", 32'(lat), 32'd2);
    chk("m0_operand", 32'(operand), 32'h1234);
    chk("m0_is_reg", 32'(is_reg), 32'd1);
    chk("m0_eff_addr", 32'(eff_addr), 32'd0);
    @(negedge clk);
    chk("m0_no_req", 32'(req_count - rq0), 32'd0);
    chk("m0_no_wr", 32'(wr_count - wr0), 32'd0);

    // Mode 2 byte on R3 at odd address: high byte
    wr0 = wr_count;
    do_fetch(3'd2, 3'd3, 1'b1, lat);
    chk("m2b_latency", 32'(lat), 32'd3);
    chk("m2b_operand", 32'(operand), 32'h00AB);
    chk("m2b_eff_addr", 32'(eff_addr), 32'h1001);
    chk("m2b_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    chk("m2b_r3", 32'(regs[3]), 32'h1002);
    chk("m2b_wr_cnt", 32'(wr_count - wr0), 32'd1);

    // Mode 2 byte on SP steps by 2
    do_fetch(3'd2, 3'd6, 1'b1, lat);
    chk("m2sp_operand", 32'(operand), 32'h0012);
    @(negedge clk);
    chk("m2sp_sp", 32'(regs[6]), 32'h1002);

    // Mode 3 word on R1
    do_fetch(3'd3, 3'd1, 1'b0, lat);
    chk("m3_latency", 32'(lat), 32'd4);
    chk("m3_operand", 32'(operand), 32'hBEEF);
    chk("m3_eff_addr", 32'(eff_addr), 32'h0300);
    @(negedge clk);
    chk("m3_r1", 32'(regs[1]), 32'h0202);

    // Mode 4 word on odd R4: error, no memory access, side effect kept
    rq0 = req_count;
    do_fetch(3'd4, 3'd4, 1'b0, lat);
    chk("m4_latency", 32'(lat), 32'd2);
    chk("m4_addr_err", 32'(addr_err), 32'd1);
    chk("m4_operand", 32'(operand), 32'd0);
    @(negedge clk);
    chk("m4_r4", 32'(regs[4]), 32'h0101);
    chk("m4_no_req", 32'(req_count - rq0), 32'd0);

    // Mode 7 on PC with two wait states per access
    waits = 2;
    wr0 = wr_count;
    do_fetch(3'd7, 3'd7, 1'b0, lat);
    chk("m7_latency", 32'(lat), 32'd11);
    chk("m7_operand", 32'(operand), 32'h5555);
    chk("m7_eff_addr", 32'(eff_addr), 32'h0040);
    @(negedge clk);
    chk("m7_pc", 32'(regs[7]), 32'h0012);
    chk("m7_wr_cnt", 32'(wr_count - wr0), 32'd1);

    // Reset while waiting on the pointer read
    waits = 3;
    poke(3'd1, 16'h0200);
    wr0 = wr_count;
    @(negedge clk);
    start = 1'b1; mode = 3'd3; reg_sel = 3'd1; byte_op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rp_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rp_mem_req", 32'(mem_req), 32'd0);
    chk("rp_mem_addr", 32'(mem_addr), 32'd0);
    chk("rp_busy", 32'(busy), 32'd0);
    chk("rp_rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rp_rd_sel", 32'(rf_rd_sel), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    waits = 0;
    do_fetch(3'd0, 3'd2, 1'b0, lat);
    chk("rp_m0_latency", 32'(lat), 32'd2);
    chk("rp_m0_operand", 32'(operand), 32'h1234);
    @(negedge clk);
    chk("rp_r1_kept", 32'(regs[1]), 32'h0200);
    chk("rp_no_wr", 32'(wr_count - wr0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
